// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer.
package mult_pkg;

    // Default operand/result width of the multiplier.
    localparam int unsigned MULT_WIDTH = 8;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width: must hold the values 0..width-1 plus headroom.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_fadder.sv
// FAdder: WIDTH-bit ripple adder with carry-in and carry-out.
module FAdder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Full-width add; the extra bit is the carry-out.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: iterative unsigned shift-and-add multiplier with a
// start/ready/done handshake. outWire is the low WIDTH bits of the product,
// errorWire flags a non-zero high half.
// Optional build macro: MULT_EARLY_EXIT_EN -- finish as soon as the remaining
// multiplier bits are all zero.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] second,
    input  logic             clear,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] outWire,
    output logic             errorWire
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;
    logic             last;
    logic             finish;
    logic [WIDTH-1:0] res_lo;
    logic             res_err;

`ifdef MULT_EARLY_EXIT_EN
    logic [CNT_W-1:0]   rem;
    logic [2*WIDTH-1:0] aligned;
`endif

    FAdder #(.WIDTH(WIDTH)) u_fadder (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Partial-product add, right shift of the accumulator and completion decode.
    always_comb begin
        addend = mcand & {WIDTH{mplier[0]}};
        // Carry-out re-enters at the top so the shifted accumulator loses nothing.
        hi_nx  = {cout, sum[WIDTH-1:1]};
        lo_nx  = {sum[0], acc_lo[WIDTH-1:1]};
        last   = (cnt == CNT_W'(WIDTH - 1));
`ifdef MULT_EARLY_EXIT_EN
        // Once the multiplier is exhausted, the pending shifts are applied in one step.
        rem     = CNT_W'(WIDTH - 1) - cnt;
        aligned = {hi_nx, lo_nx} >> rem;
        finish  = last || (mplier[WIDTH-1:1] == '0);
        res_lo  = aligned[WIDTH-1:0];
        res_err = |aligned[2*WIDTH-1:WIDTH];
`else
        finish  = last;
        res_lo  = lo_nx;
        res_err = |hi_nx;
`endif
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            outWire   <= '0;
            errorWire <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b1;
        end else if (clear) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
            ready <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        mcand  <= first;
                        mplier <= second;
                        acc_hi <= '0;
                        acc_lo <= '0;
                        cnt    <= '0;
                        done   <= 1'b0;
                        busy   <= 1'b1;
                        ready  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    acc_hi <= hi_nx;
                    acc_lo <= lo_nx;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (finish) begin
                        state     <= DONE;
                        outWire   <= res_lo;
                        errorWire <= res_err;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        ready     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed testbench for mult_seq_ctrl (WIDTH = 8).
module tb_mult_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       clear;
    logic [7:0] first;
    logic [7:0] second;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] outWire;
    logic       errorWire;

    int tests = 0;
    int fails = 0;

`ifdef MULT_EARLY_EXIT_EN
    localparam int C_7X9 = 5;
    localparam int C_6X7 = 4;
    localparam int C_B1  = 4;
    localparam int C_B2  = 9;
`else
    localparam int C_7X9 = 9;
    localparam int C_6X7 = 9;
    localparam int C_B1  = 9;
    localparam int C_B2  = 18;
`endif

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first     (first),
        .second    (second),
        .clear     (clear),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .outWire   (outWire),
        .errorWire (errorWire)
    );

    // Called at a falling edge: issues one operation and returns at the falling
    // edge where done is high (or when the cycle budget runs out).
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output int cyc, output bit timeout);
        first  = a;
        second = b;
        start  = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        timeout = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; clear = 1'b0; first = '0; second = '0;
        repeat (2) @(negedge clk);
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (outWire !== 8'h00) begin fails++; $display("FAIL reset_out: got %h want 00", outWire); end
        tests++; if (errorWire !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", errorWire); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] va [5] = '{8'd7, 8'd16, 8'd255, 8'd0,   8'd200};
        logic [7:0] vb [5] = '{8'd9, 8'd16, 8'd255, 8'd200, 8'd1};
        logic [7:0] vo [5] = '{8'h3F, 8'h00, 8'h01, 8'h00, 8'd200};
        logic       ve [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int cyc;
        bit to;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            do_op(va[i], vb[i], cyc, to);
            tests++; if (to) begin fails++; $display("FAIL basic_timeout[%0d]: no done within %0d cycles", i, cyc); end
            tests++; if (outWire !== vo[i]) begin fails++; $display("FAIL basic_out[%0d]: %0d*%0d got %h want %h", i, va[i], vb[i], outWire, vo[i]); end
            tests++; if (errorWire !== ve[i]) begin fails++; $display("FAIL basic_err[%0d]: got %b want %b", i, errorWire, ve[i]); end
            if (i == 0) begin
                tests++; if (cyc != C_7X9) begin fails++; $display("FAIL basic_latency: done in cycle %0d want %0d", cyc, C_7X9); end
                @(negedge clk);
                tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width: got %b want 0", done); end
                tests++; if (ready !== 1'b1) begin fails++; $display("FAIL basic_ready_after: got %b want 1", ready); end
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b want 0", busy); end
                tests++; if (outWire !== 8'h3F) begin fails++; $display("FAIL basic_out_held: got %h want 3f", outWire); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int c;
        @(negedge clk);
        first = 8'd6; second = 8'd7; start = 1'b1;
        @(posedge clk);
        c = 1;
        @(negedge clk);
        start = 1'b0; first = 8'd255; second = 8'd255;
        while (!done && c < 40) begin
            start = (c == 2);
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        start = 1'b0;
        tests++; if (!done) begin fails++; $display("FAIL ignore_timeout: no done within %0d cycles", c); end
        tests++; if (outWire !== 8'd42) begin fails++; $display("FAIL ignore_out: got %0d want 42", outWire); end
        tests++; if (errorWire !== 1'b0) begin fails++; $display("FAIL ignore_err: got %b want 0", errorWire); end
        tests++; if (c != C_6X7) begin fails++; $display("FAIL ignore_latency: done in cycle %0d want %0d", c, C_6X7); end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_no_requeue: busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int c;
        int pulses;
        int pc [2];
        logic [7:0] po [2];
        logic pe [2];
        @(negedge clk);
        first = 8'd3; second = 8'd5; start = 1'b1;
        @(posedge clk);
        c = 1;
        @(negedge clk);
        first = 8'd12; second = 8'd12;
        pulses = 0;
        pc = '{0, 0}; po = '{8'h00, 8'h00}; pe = '{1'b0, 1'b0};
        while (c < 40) begin
            if (done) begin
                if (pulses < 2) begin
                    pc[pulses] = c; po[pulses] = outWire; pe[pulses] = errorWire;
                end
                pulses++;
            end else if (pulses == 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        start = 1'b0;
        tests++; if (pulses != 2) begin fails++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        tests++; if (pc[0] != C_B1) begin fails++; $display("FAIL b2b_cycle1: got %0d want %0d", pc[0], C_B1); end
        tests++; if (po[0] !== 8'd15 || pe[0] !== 1'b0) begin fails++; $display("FAIL b2b_res1: got %0d/%b want 15/0", po[0], pe[0]); end
        tests++; if (pc[1] != C_B2) begin fails++; $display("FAIL b2b_cycle2: got %0d want %0d", pc[1], C_B2); end
        tests++; if (po[1] !== 8'd144 || pe[1] !== 1'b0) begin fails++; $display("FAIL b2b_res2: got %0d/%b want 144/0", po[1], pe[1]); end
    endtask

    task automatic test_rst_mid();
        int cyc;
        bit to;
        int seen;
        @(negedge clk);
        do_op(8'd7, 8'd9, cyc, to);
        tests++; if (to || outWire !== 8'h3F) begin fails++; $display("FAIL rstmid_setup: got %h want 3f", outWire); end
        @(negedge clk);
        first = 8'd100; second = 8'd200; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        tests++; if (outWire !== 8'h00) begin fails++; $display("FAIL rstmid_out: got %h want 00", outWire); end
        tests++; if (errorWire !== 1'b0) begin fails++; $display("FAIL rstmid_err: got %b want 0", errorWire); end
        tests++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl: ready/busy/done got %b%b%b want 100", ready, busy, done); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin @(negedge clk); if (done) seen++; end
        tests++; if (seen != 0) begin fails++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen); end
    endtask

    task automatic test_clear_mid();
        int cyc;
        bit to;
        int seen;
        @(negedge clk);
        do_op(8'd255, 8'd255, cyc, to);
        tests++; if (to || outWire !== 8'h01 || errorWire !== 1'b1) begin fails++; $display("FAIL clear_setup: got %h/%b want 01/1", outWire, errorWire); end
        @(negedge clk);
        first = 8'd9; second = 8'd200; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        clear = 1'b1; start = 1'b1; first = 8'd3; second = 8'd3;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        tests++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL clear_ctrl: ready/busy/done got %b%b%b want 100", ready, busy, done); end
        tests++; if (outWire !== 8'h01 || errorWire !== 1'b1) begin fails++; $display("FAIL clear_held: got %h/%b want 01/1", outWire, errorWire); end
        seen = 0;
        repeat (12) begin @(negedge clk); if (done) seen++; end
        tests++; if (seen != 0) begin fails++; $display("FAIL clear_no_done: got %0d pulses want 0", seen); end
    endtask

`ifdef MULT_EARLY_EXIT_EN
    task automatic test_early_exit();
        int cyc;
        bit to;
        @(negedge clk);
        do_op(8'd5, 8'd3, cyc, to);
        tests++; if (to || cyc != 3) begin fails++; $display("FAIL early_5x3_cycle: got %0d want 3", cyc); end
        tests++; if (outWire !== 8'd15 || errorWire !== 1'b0) begin fails++; $display("FAIL early_5x3_res: got %0d/%b want 15/0", outWire, errorWire); end
        @(negedge clk);
        do_op(8'd5, 8'd0, cyc, to);
        tests++; if (to || cyc != 2) begin fails++; $display("FAIL early_5x0_cycle: got %0d want 2", cyc); end
        tests++; if (outWire !== 8'd0 || errorWire !== 1'b0) begin fails++; $display("FAIL early_5x0_res: got %0d/%b want 0/0", outWire, errorWire); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_start_ignored();
        test_back_to_back();
        test_rst_mid();
        test_clear_mid();
`ifdef MULT_EARLY_EXIT_EN
        test_early_exit();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
